// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between IF and ID: a circular buffer of {pc, instruction} pairs.
// Optional zero-latency bypass when empty is enabled by defining FETCH_QUEUE_BYPASS_EN.

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module if_fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int WORD_WIDTH = `WORD_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WORD_WIDTH-1:0]    if_pc,
  input  logic [WORD_WIDTH-1:0]    if_instruction,
  output logic                     if_freeze,
  input  logic                     flush,
  input  logic                     id_freeze,
  output logic                     id_valid,
  output logic [WORD_WIDTH-1:0]    id_pc,
  output logic [WORD_WIDTH-1:0]    id_instruction,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WORD_WIDTH-1:0] mem_pc_q  [DEPTH];
  logic [WORD_WIDTH-1:0] mem_ins_q [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic full;
  logic empty;
  logic enq;
  logic deq;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign if_freeze = full;
  assign count     = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;

  // Bypass is gated by rst so the outputs read zero while reset is held.
  assign byp = empty & ~flush & ~rst;

  always_comb begin
    id_valid       = (~empty & ~flush) | byp;
    id_pc          = mem_pc_q[rd_ptr_q];
    id_instruction = mem_ins_q[rd_ptr_q];
    if (byp) begin
      id_pc          = if_pc;
      id_instruction = if_instruction;
    end
    enq = ~full & ~flush & ~(byp & ~id_freeze);
    deq = ~empty & ~flush & ~id_freeze;
  end
`else
  always_comb begin
    id_valid       = ~empty & ~flush;
    id_pc          = mem_pc_q[rd_ptr_q];
    id_instruction = mem_ins_q[rd_ptr_q];
    enq            = ~full & ~flush;
    deq            = ~empty & ~flush & ~id_freeze;
  end
`endif

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap to 0.
      if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      if (enq && !deq)      count_d = count_q + CW'(1);
      else if (deq && !enq) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left untouched by flush; only pointers and occupancy reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]  <= '0;
        mem_ins_q[i] <= '0;
      end
    end else if (enq) begin
      mem_pc_q[wr_ptr_q]  <= if_pc;
      mem_ins_q[wr_ptr_q] <= if_instruction;
    end
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction fetch queue between the IF stage and the ID stage of the ARM pipeline. Every cycle the IF stage is not frozen, the block captures the `{pc, instruction}` pair the IF stage presents. It delivers these pairs in order to the decode side with a valid/stall handshake, and drives the IF stage's `freeze` input when storage is full. A taken branch flushes all buffered wrong-path fetches.

## Interface

Parameters:
- `DEPTH`, 4, number of entries; a power of two, minimum 2.
- `WORD_WIDTH`, `` `WORD_WIDTH `` (32), width of pc and instruction.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_pc`  in  WORD_WIDTH  pc value reported by the IF stage with the instruction; stored unchanged.
- `if_instruction`  in  WORD_WIDTH  instruction fetched by the IF stage.
- `if_freeze`  out  1  connects to the IF stage `freeze` input; high means the IF stage holds its PC.
- `flush`  in  1  branch taken in EXE; the same signal that drives the IF stage `branch_taken` input.
- `id_freeze`  in  1  ID-side stall from the hazard unit.
- `id_valid`  out  1  head entry is valid.
- `id_pc`  out  WORD_WIDTH  pc of the head entry.
- `id_instruction`  out  WORD_WIDTH  instruction of the head entry.
- `count`  out  log2(DEPTH)+1  number of occupied entries.

## Operation

- Storage is a circular buffer of DEPTH registered entries, with a write pointer, a read pointer and an occupancy counter. Pointers wrap modulo DEPTH.
- `full = (count == DEPTH)`.
- `if_freeze = full`. It is derived from registered state only, with no combinational path from `id_freeze` or `flush`.
- Enqueue condition: `~full & ~flush`. It writes `{if_pc, if_instruction}` at the write pointer, and the write pointer increments.
- Dequeue condition: `id_valid & ~id_freeze`. The read pointer increments.
- `id_valid = (count != 0) & ~flush`.
- `id_pc` and `id_instruction` are read from the entry at the read pointer.
- Enqueue and dequeue in the same cycle leave `count` unchanged.
- When full, the block does not enqueue even if a dequeue occurs in that cycle. This costs one bubble and keeps `if_freeze` registered.
- Because the IF stage holds its PC while frozen, the same instruction is re-presented on the next cycle. No fetch is lost or duplicated.
- Flush has priority over every other condition:
  - Read pointer, write pointer and `count` are cleared to 0.
  - The incoming fetch in the flush cycle is discarded, because it is wrong-path.
  - No dequeue occurs in the flush cycle.
- Storage contents are not cleared on flush; only the pointers and counter are.

## Timing

- Reset (asynchronous): both pointers 0, `count` 0, all storage entries 0.
  - Output values during reset: `id_valid` 0, `id_pc` 0, `id_instruction` 0, `if_freeze` 0.
- Latency without bypass: a pair enqueued at edge N is visible with `id_valid` = 1 during cycle N+1.
- Throughput: one entry per cycle in each direction while not full and not empty.
- Full boundary: `if_freeze` rises in the cycle after the DEPTH-th enqueue. It falls in the cycle after the first dequeue from full.
- Empty boundary: `id_valid` = 0. `id_freeze` is ignored when `id_valid` = 0.
- Wrap-around: a pointer at DEPTH-1 advances to 0.
- Reset asserted mid-operation: all state clears immediately, regardless of `clk`.
- Flush while full: `count` is 0 after the edge and `if_freeze` drops in the next cycle.

## Configuration

- Macro: `FETCH_QUEUE_BYPASS_EN`.
- Defined:
  - When `count == 0` and `~flush`, the block presents `if_pc` and `if_instruction` directly on `id_pc` and `id_instruction`, with `id_valid` = 1 in the same cycle (zero latency).
  - If `id_freeze` = 0 in that cycle, the pair is consumed and not written to storage.
  - If `id_freeze` = 1, the pair is enqueued normally.
- Not defined:
  - Every fetch passes through storage, giving a minimum latency of 1 cycle.
  - `id_*` outputs depend only on registered state and `flush`.

## Test plan

- Reset, then stream with `id_freeze` = 0 and no bypass:
  - pcs 1, 2, 3 enqueued at edges 1, 2, 3 appear on `id_pc` in cycles 2, 3, 4.
  - `count` stays at 1.
  - `if_freeze` stays 0.
- Hold `id_freeze` = 1 with DEPTH = 4:
  - after 4 enqueues, `count` = 4 and `if_freeze` = 1.
  - the same `if_pc` is held and is not re-enqueued.
  - releasing the stall drains the pairs in order 1, 2, 3, 4, and `if_freeze` falls after the first dequeue.
- Assert `flush` for one cycle with `count` = 3:
  - `id_valid` = 0 in the flush cycle, and `count` = 0 after the edge.
  - the fetch presented in the flush cycle never appears at ID.
  - the next fetch (branch target pc 0x20) is delivered first.
- Run 10 enqueue/dequeue pairs with DEPTH = 4:
  - pointers wrap twice.
  - output order matches input order exactly.
- Assert `rst` between clock edges with `count` = 2:
  - `id_valid`, `count` and `if_freeze` go to 0 immediately.
  - the first fetch after release is delivered correctly.
- With `FETCH_QUEUE_BYPASS_EN` defined and the queue empty:
  - pc 0x10 is visible on `id_pc` in the same cycle with `id_valid` = 1, and `count` remains 0.
  - with `id_freeze` = 1, `count` becomes 1.
